// File: rtl/reg_file_cmd_ctrl.sv
// Command sequencer between the UART byte streams and a 16-entry register file.
// Decodes {WR_CMD, addr, data} and {RD_CMD, addr} frames and returns read bytes to UART TX.
module reg_file_cmd_ctrl #(
  parameter int unsigned           DATA_SIZE     = 8,
  parameter int unsigned           ADDRESS_WIDTH = 4,
  parameter logic [DATA_SIZE-1:0]  WR_CMD        = 8'hAA,
  parameter logic [DATA_SIZE-1:0]  RD_CMD        = 8'hBB,
  parameter int unsigned           TIMEOUT       = 8
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic [DATA_SIZE-1:0]     RX_P_DATA,
  input  logic                     RX_D_VLD,
  input  logic [DATA_SIZE-1:0]     RF_RdData,
  input  logic                     RF_RdData_Valid,
  input  logic                     TX_BUSY,
  output logic [ADDRESS_WIDTH-1:0] RF_Address,
  output logic                     RF_WrEn,
  output logic                     RF_RdEn,
  output logic [DATA_SIZE-1:0]     RF_WrData,
  output logic [DATA_SIZE-1:0]     TX_P_DATA,
  output logic                     TX_D_VLD,
  output logic                     CMD_ERR,
  output logic                     CTRL_BUSY
);

  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE,
    WR_ADDR,
    WR_DATA,
    RD_ADDR,
    RD_WAIT,
    TX_SEND
  } state_t;

  state_t                   state, state_n;
  logic [DATA_SIZE-1:0]     addr_q, addr_n;
  logic [CNT_W-1:0]         cnt, cnt_n;
  logic [ADDRESS_WIDTH-1:0] rf_address_n;
  logic [DATA_SIZE-1:0]     rf_wr_data_n;
  logic [DATA_SIZE-1:0]     tx_p_data_n;
  logic                     wr_en_n, rd_en_n, tx_vld_n, err_n, busy_n;

  // An address byte is legal only when every bit above the register-file index is zero.
  function automatic logic in_range(input logic [DATA_SIZE-1:0] b);
    return ~|(b >> ADDRESS_WIDTH);
  endfunction

  always_comb begin
    state_n      = state;
    addr_n       = addr_q;
    cnt_n        = cnt;
    rf_address_n = RF_Address;
    rf_wr_data_n = RF_WrData;
    tx_p_data_n  = TX_P_DATA;
    wr_en_n      = 1'b0;
    rd_en_n      = 1'b0;
    tx_vld_n     = 1'b0;
    err_n        = 1'b0;

    case (state)
      IDLE: begin
        if (RX_D_VLD) begin
          if (RX_P_DATA == WR_CMD) begin
            state_n = WR_ADDR;
          end else if (RX_P_DATA == RD_CMD) begin
            state_n = RD_ADDR;
          end else begin
            err_n = 1'b1;
          end
        end
      end

      WR_ADDR: begin
        if (RX_D_VLD) begin
          addr_n  = RX_P_DATA;
          state_n = WR_DATA;
        end
      end

      WR_DATA: begin
        if (RX_D_VLD) begin
          if (in_range(addr_q)) begin
            rf_address_n = addr_q[ADDRESS_WIDTH-1:0];
            rf_wr_data_n = RX_P_DATA;
            wr_en_n      = 1'b1;
          end else begin
            err_n = 1'b1;
          end
          state_n = IDLE;
        end
      end

      RD_ADDR: begin
        if (RX_D_VLD) begin
          if (in_range(RX_P_DATA)) begin
            addr_n       = RX_P_DATA;
            rf_address_n = RX_P_DATA[ADDRESS_WIDTH-1:0];
            rd_en_n      = 1'b1;
            cnt_n        = '0;
            state_n      = RD_WAIT;
          end else begin
            err_n   = 1'b1;
            state_n = IDLE;
          end
        end
      end

      // Valid data with TX idle goes straight out so TX_D_VLD lands three cycles after the address byte.
      RD_WAIT: begin
        cnt_n = cnt + 1'b1;
        if (RX_D_VLD) begin
          err_n = 1'b1;
        end
        if (RF_RdData_Valid) begin
          tx_p_data_n = RF_RdData;
          if (!TX_BUSY) begin
            tx_vld_n = 1'b1;
            state_n  = IDLE;
          end else begin
            state_n = TX_SEND;
          end
        end else if (cnt == CNT_LAST) begin
          err_n   = 1'b1;
          state_n = IDLE;
        end
      end

      TX_SEND: begin
        if (RX_D_VLD) begin
          err_n = 1'b1;
        end
        if (!TX_BUSY) begin
          tx_vld_n = 1'b1;
          state_n  = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      addr_q     <= '0;
      cnt        <= '0;
      RF_Address <= '0;
      RF_WrData  <= '0;
      TX_P_DATA  <= '0;
      RF_WrEn    <= 1'b0;
      RF_RdEn    <= 1'b0;
      TX_D_VLD   <= 1'b0;
      CMD_ERR    <= 1'b0;
      CTRL_BUSY  <= 1'b0;
    end else begin
      state      <= state_n;
      addr_q     <= addr_n;
      cnt        <= cnt_n;
      RF_Address <= rf_address_n;
      RF_WrData  <= rf_wr_data_n;
      TX_P_DATA  <= tx_p_data_n;
      RF_WrEn    <= wr_en_n;
      RF_RdEn    <= rd_en_n;
      TX_D_VLD   <= tx_vld_n;
      CMD_ERR    <= err_n;
      CTRL_BUSY  <= busy_n;
    end
  end

endmodule
